alu_cmd_sequencer: RTL and testbench
====================================

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, command FIFO entries (power of 2, >=2).
REQ-003 SHALL have port clk input 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst input 1: reset, synchronous, active-high.
REQ-005 SHALL have port cmd_valid input 1: upstream command valid.
REQ-006 SHALL have port cmd_ready output 1: command accept, equals FIFO not full.
REQ-007 SHALL have port cmd_opcode input 4: ALU opcode; 0-7 legal, 8-15 illegal.
REQ-008 SHALL have ports cmd_a, cmd_b input DATA_WIDTH: operands.
REQ-009 SHALL have port cmd_use_acc input 1: replace cmd_a with accumulator at issue.
REQ-010 SHALL have port cmd_tag input 4: ID returned with response.
REQ-011 SHALL have ports alu_opcode output 4, alu_operand_a and alu_operand_b output DATA_WIDTH: drive downstream ALU core from registers.
REQ-012 SHALL have ports alu_result input DATA_WIDTH, alu_zero input 1, alu_carry input 1: combinational ALU return.
REQ-013 SHALL have ports rsp_valid output 1, rsp_ready input 1: response handshake.
REQ-014 SHALL have ports rsp_result output DATA_WIDTH, rsp_zero, rsp_carry, rsp_err output 1, rsp_tag output 4.
REQ-015 SHALL have port acc output DATA_WIDTH: accumulator value; port cmd_count output log2(FIFO_DEPTH)+1: FIFO occupancy.

Function
REQ-016 SHALL push a command into the FIFO on each rising edge with cmd_valid and cmd_ready both high; cmd_ready derives from registered count only, so no push when full even if a pop occurs that cycle.
REQ-017 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-018 In IDLE with FIFO non-empty, SHALL pop head, load opcode/operand/tag registers (operand_a = acc if use_acc else cmd_a), go EXEC.
REQ-019 In EXEC (exactly one cycle) SHALL capture alu_result, alu_zero, alu_carry into response registers, go RESP; rsp_valid high from next cycle.
REQ-020 Latency: command accepted at edge N with empty FIFO and IDLE -> pop at N+1, capture at N+2, rsp_valid high in cycle after N+2.
REQ-021 In RESP SHALL hold rsp_valid and all rsp_* stable until rsp_ready; on handshake go EXEC with next pop if FIFO non-empty, else IDLE.
REQ-022 Illegal opcode (8-15): SHALL still pass through EXEC, drive alu_opcode as given, respond rsp_err=1, rsp_result=0, rsp_zero=1, rsp_carry=0, acc unchanged.
REQ-023 Legal opcode: SHALL update acc with alu_result at the EXEC capture edge; rsp_err=0.
REQ-024 Back-to-back throughput SHALL be one response per two cycles with rsp_ready held high.
REQ-025 Simultaneous push and pop SHALL leave cmd_count unchanged; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-026 Commands SHALL complete in acceptance order; rsp_tag equals the issuing cmd_tag.
REQ-027 alu_* outputs SHALL change only at pop edges.

Reset
REQ-028 rst high at an edge SHALL force IDLE, empty FIFO (cmd_count=0, cmd_ready=1), rsp_valid=0, all rsp_*=0, acc=0, alu_* outputs=0.
REQ-029 Reset mid-operation (EXEC or RESP) SHALL discard in-flight and queued commands with no response emitted.
REQ-030 cmd_valid SHALL be ignored during any cycle rst is high.

Verification
REQ-031 ADD a=5 b=3 tag=1, rsp_ready=1 -> rsp_valid third cycle after accept, result=8, zero=0, carry=0, tag=1, acc=8.
REQ-032 SUB a=2 b=3, then SUB use_acc=1 b=0xFFFFFFFF -> first result 0xFFFFFFFF carry=1; second operand_a=0xFFFFFFFF, result=0, zero=1.
REQ-033 Push 5 commands, rsp_ready=0 -> cmd_ready low after 4 pushes into empty FIFO plus 1 in EXEC; no loss; raising rsp_ready returns tags in order.
REQ-034 Opcode 4'hA tag=7 -> rsp_err=1, result=0, zero=1, acc unchanged.
REQ-035 rst asserted in RESP with 2 queued -> next cycle rsp_valid=0, cmd_count=0, acc=0; no stale response after release.
REQ-036 rsp_ready toggled randomly with continuous cmd_valid -> rsp_* stable while rsp_valid && !rsp_ready; count of responses equals accepted commands.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//
// Queues ALU commands in a small FIFO and issues them one at a time to an
// external combinational ALU core. It captures the ALU return into response
// registers and presents each response through a valid/ready handshake. It
// also keeps an accumulator that legal opcodes update and that can stand in
// for operand A.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid / cmd_ready    command handshake (ready = FIFO not full)
//   cmd_opcode, cmd_a, cmd_b command fields; opcodes 8-15 are illegal
//   cmd_use_acc, cmd_tag     use accumulator as operand A; response ID
//   alu_opcode, alu_operand_a, alu_operand_b   registered drive to ALU core
//   alu_result, alu_zero, alu_carry            combinational ALU return
//   rsp_valid / rsp_ready    response handshake
//   rsp_result, rsp_zero, rsp_carry, rsp_err, rsp_tag   response fields
//   acc                      accumulator
//   cmd_count                FIFO occupancy
module alu_cmd_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [3:0]                    cmd_opcode,
    input  logic [DATA_WIDTH-1:0]         cmd_a,
    input  logic [DATA_WIDTH-1:0]         cmd_b,
    input  logic                          cmd_use_acc,
    input  logic [3:0]                    cmd_tag,
    output logic [3:0]                    alu_opcode,
    output logic [DATA_WIDTH-1:0]         alu_operand_a,
    output logic [DATA_WIDTH-1:0]         alu_operand_b,
    input  logic [DATA_WIDTH-1:0]         alu_result,
    input  logic                          alu_zero,
    input  logic                          alu_carry,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_result,
    output logic                          rsp_zero,
    output logic                          rsp_carry,
    output logic                          rsp_err,
    output logic [3:0]                    rsp_tag,
    output logic [DATA_WIDTH-1:0]         acc,
    output logic [$clog2(FIFO_DEPTH):0]   cmd_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef struct packed {
        logic [3:0]            opcode;
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic                  use_acc;
        logic [3:0]            tag;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    entry_t        fifo_mem [FIFO_DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [3:0]    issue_tag;
    logic          push;
    logic          pop;
    logic          fifo_empty;

    // Ready comes from the registered count only, so a pop in the same cycle
    // never frees a slot for a push.
    assign cmd_ready  = (cmd_count != FULL_COUNT);
    assign fifo_empty = (cmd_count == '0);
    assign push       = cmd_valid && cmd_ready && !rst;
    assign pop        = !fifo_empty &&
                        ((state == IDLE) || ((state == RESP) && rsp_ready));
    assign head       = fifo_mem[rd_ptr];

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{opcode: cmd_opcode, a: cmd_a, b: cmd_b,
                                  use_acc: cmd_use_acc, tag: cmd_tag};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            cmd_count     <= '0;
            alu_opcode    <= '0;
            alu_operand_a <= '0;
            alu_operand_b <= '0;
            issue_tag     <= '0;
            rsp_valid     <= 1'b0;
            rsp_result    <= '0;
            rsp_zero      <= 1'b0;
            rsp_carry     <= 1'b0;
            rsp_err       <= 1'b0;
            rsp_tag       <= '0;
            acc           <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cmd_count <= cmd_count + 1'b1;
                2'b01:   cmd_count <= cmd_count - 1'b1;
                default: cmd_count <= cmd_count;
            endcase

            // Issue registers move only on a pop; the accumulator is already
            // up to date here because the previous command captured it in EXEC.
            if (pop) begin
                alu_opcode    <= head.opcode;
                alu_operand_a <= head.use_acc ? acc : head.a;
                alu_operand_b <= head.b;
                issue_tag     <= head.tag;
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_valid <= 1'b1;
                    rsp_tag   <= issue_tag;
                    if (alu_opcode[3]) begin
                        rsp_err    <= 1'b1;
                        rsp_result <= '0;
                        rsp_zero   <= 1'b1;
                        rsp_carry  <= 1'b0;
                    end else begin
                        rsp_err    <= 1'b0;
                        rsp_result <= alu_result;
                        rsp_zero   <= alu_zero;
                        rsp_carry  <= alu_carry;
                        acc        <= alu_result;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= pop ? EXEC : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: a combinational ALU model closes the loop,
// stimulus pushes expected responses into a queue, and a negedge monitor pops
// and compares them on every response handshake.
module tb_alu_cmd_sequencer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_opcode;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        cmd_use_acc;
    logic [3:0]  cmd_tag;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_operand_a;
    logic [31:0] alu_operand_b;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_carry;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_carry;
    logic        rsp_err;
    logic [3:0]  rsp_tag;
    logic [31:0] acc;
    logic [2:0]  cmd_count;

    alu_cmd_sequencer #(.DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_use_acc(cmd_use_acc), .cmd_tag(cmd_tag),
        .alu_opcode(alu_opcode), .alu_operand_a(alu_operand_a),
        .alu_operand_b(alu_operand_b),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
        .rsp_err(rsp_err), .rsp_tag(rsp_tag),
        .acc(acc), .cmd_count(cmd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU core model: 0 ADD, 1 SUB (carry = borrow), 2 AND, 3 OR, 4 XOR,
    // 5 pass B, 6 pass A, 7 NOT A. Returns {carry, result}.
    function automatic logic [32:0] alu_f(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            4'd0:    alu_f = {1'b0, a} + {1'b0, b};
            4'd1:    alu_f = {(a < b), a - b};
            4'd2:    alu_f = {1'b0, a & b};
            4'd3:    alu_f = {1'b0, a | b};
            4'd4:    alu_f = {1'b0, a ^ b};
            4'd5:    alu_f = {1'b0, b};
            4'd6:    alu_f = {1'b0, a};
            4'd7:    alu_f = {1'b0, ~a};
            default: alu_f = 33'h1_DEAD_BEEF;
        endcase
    endfunction

    always_comb begin
        logic [32:0] r;
        r          = alu_f(alu_opcode, alu_operand_a, alu_operand_b);
        alu_result = r[31:0];
        alu_carry  = r[32];
        alu_zero   = (r[31:0] == 32'd0);
    end

    typedef struct {
        logic [31:0] result;
        logic        zero;
        logic        carry;
        logic        err;
        logic [3:0]  tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks    = 0;
    int   errors    = 0;
    int   accepted  = 0;
    int   responses = 0;
    logic sending   = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic use_acc,
                        input logic [3:0] tag, input logic [31:0] e_res,
                        input logic e_zero, input logic e_carry,
                        input logic e_err);
        exp_t e;
        bit   done;
        e.result = e_res; e.zero = e_zero; e.carry = e_carry;
        e.err = e_err; e.tag = tag;
        cmd_opcode = op; cmd_a = a; cmd_b = b;
        cmd_use_acc = use_acc; cmd_tag = tag;
        cmd_valid = 1'b1;
        done = 0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1 && rst === 1'b0) begin
                exp_q.push_back(e);
                accepted++;
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drain();
        bit done;
        done = 0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && rsp_valid === 1'b0) done = 1;
        end
        if (!done) check("drain_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: scoreboard compare on handshake, stability check while stalled.
    logic        hold_prev = 1'b0;
    logic [31:0] prev_result;
    logic [3:0]  prev_tag;
    logic [2:0]  prev_flags;

    always @(negedge clk) begin
        if (hold_prev) begin
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_result", rsp_result, prev_result);
            check("stall_tag", 32'(rsp_tag), 32'(prev_tag));
            check("stall_flags", 32'({rsp_zero, rsp_carry, rsp_err}), 32'(prev_flags));
        end
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1 && rst === 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got response tag %h, required none", rsp_tag);
            end else begin
                mon_e = exp_q.pop_front();
                responses++;
                check("rsp_tag", 32'(rsp_tag), 32'(mon_e.tag));
                check("rsp_result", rsp_result, mon_e.result);
                check("rsp_zero", 32'(rsp_zero), 32'(mon_e.zero));
                check("rsp_carry", 32'(rsp_carry), 32'(mon_e.carry));
                check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
            end
        end
        hold_prev   = (rsp_valid === 1'b1) && (rsp_ready === 1'b0) && (rst === 1'b0);
        prev_result = rsp_result;
        prev_tag    = rsp_tag;
        prev_flags  = {rsp_zero, rsp_carry, rsp_err};
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_opcode = '0; cmd_a = '0; cmd_b = '0; cmd_use_acc = 1'b0; cmd_tag = '0;

        // Reset, with cmd_valid asserted to confirm it is ignored.
        repeat (2) @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_cmd_count", 32'(cmd_count), 32'd0);
        check("rst_acc", acc, 32'd0);
        check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
        check("rst_alu_operand_a", alu_operand_a, 32'd0);
        check("rst_rsp_result", rsp_result, 32'd0);
        cmd_valid = 1'b0;
        rst = 1'b0;

        // ADD 5+3 with latency check.
        rsp_ready = 1'b1;
        send(4'd0, 32'd5, 32'd3, 1'b0, 4'd1, 32'd8, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("lat_pop_cycle_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_capture_valid", 32'(rsp_valid), 32'd1);
        check("add_acc", acc, 32'd8);
        wait_drain();

        // SUB 2-3, then SUB acc - 0xFFFFFFFF using the accumulator.
        send(4'd1, 32'd2, 32'd3, 1'b0, 4'd2, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
        send(4'd1, 32'h1234, 32'hFFFF_FFFF, 1'b1, 4'd3, 32'd0, 1'b1, 1'b0, 1'b0);
        wait_drain();
        check("sub_use_acc_operand_a", alu_operand_a, 32'hFFFF_FFFF);
        check("sub_acc", acc, 32'd0);

        // Fill with rsp_ready low: one command in flight plus four queued.
        rsp_ready = 1'b0;
        send(4'd0, 32'd1, 32'd1, 1'b0, 4'd8, 32'd2, 1'b0, 1'b0, 1'b0);
        send(4'd0, 32'd2, 32'd2, 1'b0, 4'd9, 32'd4, 1'b0, 1'b0, 1'b0);
        send(4'd0, 32'd3, 32'd3, 1'b0, 4'd10, 32'd6, 1'b0, 1'b0, 1'b0);
        send(4'd0, 32'd4, 32'd4, 1'b0, 4'd11, 32'd8, 1'b0, 1'b0, 1'b0);
        send(4'd0, 32'h10, 32'h5, 1'b0, 4'd12, 32'h15, 1'b0, 1'b0, 1'b0);
        check("full_cmd_ready", 32'(cmd_ready), 32'd0);
        check("full_cmd_count", 32'(cmd_count), 32'd4);
        repeat (3) @(posedge clk);
        #1;
        check("full_hold_cmd_ready", 32'(cmd_ready), 32'd0);
        check("full_rsp_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        wait_drain();
        check("fill_acc", acc, 32'h15);

        // Illegal opcode leaves the accumulator alone.
        send(4'hA, 32'd1, 32'd2, 1'b0, 4'd7, 32'd0, 1'b1, 1'b0, 1'b1);
        wait_drain();
        check("illegal_acc", acc, 32'h15);
        check("illegal_alu_opcode", 32'(alu_opcode), 32'hA);

        // Reset while in RESP with two commands queued.
        rsp_ready = 1'b0;
        send(4'd0, 32'd1, 32'd1, 1'b0, 4'd4, 32'd2, 1'b0, 1'b0, 1'b0);
        send(4'd0, 32'd2, 32'd1, 1'b0, 4'd5, 32'd3, 1'b0, 1'b0, 1'b0);
        send(4'd0, 32'd3, 32'd1, 1'b0, 4'd6, 32'd4, 1'b0, 1'b0, 1'b0);
        check("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
        check("pre_rst_cmd_count", 32'(cmd_count), 32'd2);
        check("pre_rst_acc", acc, 32'd2);
        rst = 1'b1;
        cmd_valid = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_cmd_count", 32'(cmd_count), 32'd0);
        check("mid_rst_acc", acc, 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        check("rst_ignores_valid", 32'(cmd_count), 32'd0);
        rst = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("no_stale_rsp", 32'(rsp_valid), 32'd0);
        end

        // Continuous commands with randomly toggling rsp_ready.
        accepted = 0;
        responses = 0;
        sending = 1'b1;
        fork
            begin
                for (int k = 0; k < 12; k++) begin
                    logic [31:0] a, b;
                    logic [32:0] r;
                    logic [3:0]  op;
                    a  = $urandom;
                    b  = $urandom;
                    op = 4'($urandom_range(0, 4));
                    r  = alu_f(op, a, b);
                    send(op, a, b, 1'b0, 4'(k), r[31:0], (r[31:0] == 32'd0),
                         r[32], 1'b0);
                end
                sending = 1'b0;
            end
            begin
                for (int c = 0; c < 3000 && sending; c++) begin
                    @(posedge clk);
                    #1;
                    rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        rsp_ready = 1'b1;
        wait_drain();
        check("rand_accepted", 32'(accepted), 32'd12);
        check("rand_responses", 32'(responses), 32'(accepted));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
